// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the serial packed-BCD adder: FSM state encodings,
// BCD digit limits and a digit validity helper.
package bcd_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic bcd_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    s  = t[3:0];
    co = 1'b0;
    // Invalid digits go through the same correction; only the flag reports them.
    if (t > {1'b0, BCD_MAX}) begin
      s  = t[3:0] + BCD_ADJ;
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer for an N-digit packed-BCD addition, one digit pair per clock,
// least significant digit first, through a single shared digit adder.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   addend,
  input  logic [4*DIGITS-1:0]   augend,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  digit_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, busy_q, done_q, cout_q, err_q;

  logic [3:0]      a_dig_d, b_dig_d, s_dig;
  logic            co_dig;

  always_comb begin
    a_dig_d = '0;
    b_dig_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig_d = a_q[i*4 +: 4];
        b_dig_d = b_q[i*4 +: 4];
      end
    end
  end

  bcd_digit_add u_digit (
    .a  (a_dig_d),
    .b  (b_dig_d),
    .ci (carry_q),
    .s  (s_dig),
    .co (co_dig)
  );

  // Operand registers are data only and are not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= addend;
            b_q     <= augend;
            carry_q <= carry_in;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) sum_q[i*4 +: 4] <= s_dig;
          end
          carry_q <= co_dig;
          err_q   <= err_q | bcd_invalid(a_dig_d) | bcd_invalid(b_dig_d);
          if (idx_q == IDX_LAST) begin
            cout_q  <= co_dig;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for the serial BCD adder sequencer with a transaction-level
// reference model compared against the DUT every cycle.
module tb_bcd_serial_add_ctrl;

  localparam int DIG = 4;

  logic        clk = 1'b0;
  logic        reset, start, carry_in;
  logic [15:0] addend, augend;
  logic        busy, done, carry_out, digit_err;
  logic [15:0] sum;

  logic        start1, cin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, co1, err1;
  logic [3:0]  sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .addend(addend), .augend(augend),
    .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out), .digit_err(digit_err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .addend(a1), .augend(b1),
    .carry_in(cin1), .busy(busy1), .done(done1), .sum(sum1),
    .carry_out(co1), .digit_err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Decimal addition digit by digit with plain integers.
  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [15:0] r;
    int t, cy;
    r  = '0;
    cy = int'(c);
    for (int i = 0; i < DIG; i++) begin
      t = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + cy;
      if (t > 9) begin
        r[i*4 +: 4] = 4'((t + 6) % 16);
        cy = 1;
      end else begin
        r[i*4 +: 4] = 4'(t);
        cy = 0;
      end
    end
    return {cy[0], r};
  endfunction

  function automatic logic model_err(input logic [15:0] a, input logic [15:0] b);
    logic e;
    e = 1'b0;
    for (int i = 0; i < DIG; i++)
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  // Reference: an accepted op occupies DIG cycles, then results appear with done.
  logic        model_ok = 1'b0;
  logic        m_busy, m_done, m_co, m_err, pend_err;
  logic [15:0] m_sum;
  logic [16:0] pend;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      model_ok <= 1'b1;
      m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0; m_co <= 1'b0; m_err <= 1'b0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_sum <= pend[15:0]; m_co <= pend[16]; m_err <= pend_err;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        pend     <= model_add(addend, augend, carry_in);
        pend_err <= model_err(addend, augend);
        m_left   <= DIG;
        m_busy   <= 1'b1;
        m_sum <= '0; m_co <= 1'b0; m_err <= 1'b0;
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      if (!m_busy) begin
        chk("cyc_sum", 32'(sum), 32'(m_sum));
        chk("cyc_cout", 32'(carry_out), 32'(m_co));
        chk("cyc_err", 32'(digit_err), 32'(m_err));
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(posedge clk);
    #1 addend = a; augend = b; carry_in = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int exp_n, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (done !== 1'b1 && n < 12);
    chk(name, 32'(n), 32'(exp_n));
  endtask

  task automatic chk_result(input string name, input logic [15:0] s, input logic co, input logic e);
    chk({name, "_sum"}, 32'(sum), 32'(s));
    chk({name, "_cout"}, 32'(carry_out), 32'(co));
    chk({name, "_err"}, 32'(digit_err), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; carry_in = 1'b0; addend = '0; augend = '0;
    start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_result("rst", 16'h0000, 1'b0, 1'b0);

    start_op(16'h1234, 16'h5678, 1'b0);
    wait_done(4, "t1_latency");
    chk_result("t1", 16'h6912, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_single_pulse", 32'(done), 32'd0);

    start_op(16'h9999, 16'h0001, 1'b0);
    wait_done(4, "t2a_latency");
    chk_result("t2a", 16'h0000, 1'b1, 1'b0);

    start_op(16'h0000, 16'h0000, 1'b1);
    wait_done(4, "t2b_latency");
    chk_result("t2b", 16'h0001, 1'b0, 1'b0);

    @(posedge clk);
    #1 addend = 16'h1111; augend = 16'h2222; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    wait_done(4, "t3a_latency");
    chk_result("t3a", 16'h3333, 1'b0, 1'b0);
    addend = 16'h4444; augend = 16'h5555;
    @(posedge clk);
    #1 start = 1'b0; addend = 16'h0000; augend = 16'h0000;
    @(negedge clk);
    chk("t3_b2b_busy", 32'(busy), 32'd1);
    wait_done(4, "t3b_latency");
    chk_result("t3b", 16'h9999, 1'b0, 1'b0);

    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_done", 32'(done), 32'd0);
    chk_result("t4_abort", 16'h0000, 1'b0, 1'b0);
    start_op(16'h0500, 16'h0500, 1'b0);
    wait_done(4, "t4_latency");
    chk_result("t4", 16'h1000, 1'b0, 1'b0);

    start_op(16'h00A0, 16'h0000, 1'b0);
    wait_done(4, "t5_latency");
    chk_result("t5", 16'h0100, 1'b0, 1'b1);

    @(posedge clk);
    #1 a1 = 4'd5; b1 = 4'd5; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy1), 32'd1);
    chk("t6_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    chk("t6_done", 32'(done1), 32'd1);
    chk("t6_sum", 32'(sum1), 32'd0);
    chk("t6_cout", 32'(co1), 32'd1);
    chk("t6_err", 32'(err1), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
